requant_argmax_pipe: RTL and testbench

- Streaming post-accumulator stage for the quantised net datapath. Takes wide signed MAC-sum values on a valid/ready stream and applies bias, unsigned scale, arithmetic right shift with optional rounding, output offset, and clamp to a programmable [min,max].
- Emits OUT_W-bit results on a second valid/ready stream.
- Tracks a running argmax over the first NUM_CLASSES outputs of each frame.
- Parametrised successor of the fixed 25-bit / 10-class / fixed-max-127 processing step.

---
 rtl/requant_argmax_pipe.sv | 146 ++++++++++++++
 tb/tb_requant_argmax_pipe.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/requant_argmax_pipe.sv
// requant_argmax_pipe: three-stage bias/scale/shift/offset/clamp requantiser
// with a per-frame running argmax over the first NUM_CLASSES outputs.
module requant_argmax_pipe #(
  parameter int ACC_W       = 25,
  parameter int OUT_W       = 8,
  parameter int MULT_W      = 16,
  parameter int SHIFT_W     = 5,
  parameter int NUM_CLASSES = 10,
  parameter int IDX_W       = $clog2(NUM_CLASSES)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_load,
  input  logic signed [ACC_W-1:0]  cfg_bias,
  input  logic        [MULT_W-1:0] cfg_mult,
  input  logic       [SHIFT_W-1:0] cfg_shift,
  input  logic                     cfg_round,
  input  logic signed [OUT_W-1:0]  cfg_offset,
  input  logic signed [OUT_W-1:0]  cfg_min,
  input  logic signed [OUT_W-1:0]  cfg_max,
  output logic                     busy,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [ACC_W-1:0]  in_data,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  out_data,
  output logic                     out_last,
  output logic                     argmax_valid,
  output logic        [IDX_W-1:0]  argmax_idx,
  output logic signed [OUT_W-1:0]  argmax_val
);
  localparam int SW = ACC_W + 1;
  localparam int PW = ACC_W + MULT_W + 2;
  localparam int CW = $clog2(NUM_CLASSES + 1);
  localparam logic signed [OUT_W-1:0] OMIN = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic signed [OUT_W-1:0] OMAX = {1'b0, {(OUT_W-1){1'b1}}};
  logic signed [ACC_W-1:0]  bias_q;
  logic        [MULT_W-1:0] mult_q;
  logic       [SHIFT_W-1:0] shift_q;
  logic                     round_q;
  logic signed [OUT_W-1:0]  offset_q, min_q, max_q;
  logic                     s1_v_q, s1_last_q, s2_v_q, s2_last_q, out_valid_q, out_last_q;
  logic        [PW-1:0]     s1_p_q, p_d, rnd_d;
  logic signed [PW-1:0]     s2_q_q, q_d, r_d, sh_d, lo_d, hi_d, lim_d;
  logic        [SW-1:0]     sum_d;
  logic signed [OUT_W-1:0]  out_data_q, res_d;
  logic                     en, hs, in_win, take;
  logic        [CW-1:0]     cnt_q, cnt_d;
  logic        [IDX_W-1:0]  cand_idx_q, cand_idx_d, am_idx_q;
  logic signed [OUT_W-1:0]  cand_val_q, cand_val_d, am_val_q;
  logic                     am_valid_q;
  assign en           = !out_valid_q || out_ready;
  assign in_ready     = en;
  assign busy         = s1_v_q || s2_v_q || out_valid_q;
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_last     = out_last_q;
  assign argmax_valid = am_valid_q;
  assign argmax_idx   = am_idx_q;
  assign argmax_val   = am_val_q;
  // Operands are sign/zero-extended to the full product width so the
  // unsigned multiply yields the exact signed product.
  always_comb begin
    sum_d = {in_data[ACC_W-1], in_data} + {bias_q[ACC_W-1], bias_q};
    p_d   = {{(PW-SW){sum_d[SW-1]}}, sum_d} * {{(PW-MULT_W){1'b0}}, mult_q};
    rnd_d = (round_q && shift_q != '0) ? (PW'(1) << (shift_q - SHIFT_W'(1))) : '0;
    r_d   = $signed(s1_p_q + rnd_d);
    sh_d  = r_d >>> shift_q;
    q_d   = sh_d + $signed({{(PW-OUT_W){offset_q[OUT_W-1]}}, offset_q});
    lo_d  = $signed({{(PW-OUT_W){min_q[OUT_W-1]}}, min_q});
    hi_d  = $signed({{(PW-OUT_W){max_q[OUT_W-1]}}, max_q});
    lim_d = (s2_q_q < lo_d) ? lo_d : s2_q_q;
    res_d = (lim_d > hi_d) ? max_q : lim_d[OUT_W-1:0];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bias_q      <= '0;
      mult_q      <= MULT_W'(1);
      shift_q     <= '0;
      round_q     <= 1'b0;
      offset_q    <= '0;
      min_q       <= OMIN;
      max_q       <= OMAX;
      s1_v_q      <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_p_q      <= '0;
      s2_v_q      <= 1'b0;
      s2_last_q   <= 1'b0;
      s2_q_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      if (cfg_load && !busy && !in_valid) begin
        bias_q   <= cfg_bias;
        mult_q   <= cfg_mult;
        shift_q  <= cfg_shift;
        round_q  <= cfg_round;
        offset_q <= cfg_offset;
        min_q    <= cfg_min;
        max_q    <= cfg_max;
      end
      if (en) begin
        s1_v_q      <= in_valid;
        s1_last_q   <= in_last;
        s1_p_q      <= p_d;
        s2_v_q      <= s1_v_q;
        s2_last_q   <= s1_last_q;
        s2_q_q      <= q_d;
        out_valid_q <= s2_v_q;
        out_last_q  <= s2_last_q;
        out_data_q  <= res_d;
      end
    end
  end
  // Element 0 always seeds the candidate; strict compare keeps the lowest index on ties.
  always_comb begin
    hs         = out_valid_q && out_ready;
    in_win     = cnt_q < CW'(NUM_CLASSES);
    take       = hs && in_win && (cnt_q == '0 || out_data_q > cand_val_q);
    cand_idx_d = take ? cnt_q[IDX_W-1:0] : cand_idx_q;
    cand_val_d = take ? out_data_q : cand_val_q;
    cnt_d      = !hs ? cnt_q : out_last_q ? '0 : in_win ? cnt_q + CW'(1) : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      cand_idx_q <= '0;
      cand_val_q <= OMIN;
      am_valid_q <= 1'b0;
      am_idx_q   <= '0;
      am_val_q   <= OMIN;
    end else begin
      cnt_q      <= cnt_d;
      cand_idx_q <= cand_idx_d;
      cand_val_q <= cand_val_d;
      am_valid_q <= hs && out_last_q;
      if (hs && out_last_q) begin
        am_idx_q <= cand_idx_d;
        am_val_q <= cand_val_d;
      end
    end
  end
endmodule

// File: tb/tb_requant_argmax_pipe.sv
// tb_requant_argmax_pipe: scoreboard bench for the requantiser and frame argmax.
module tb_requant_argmax_pipe;
  logic clk = 1'b0, rst_n, cfg_load, cfg_round, busy, in_valid, in_ready, in_last;
  logic out_valid, out_ready, out_last, argmax_valid;
  logic signed [24:0] cfg_bias, in_data;
  logic [15:0] cfg_mult;
  logic [4:0] cfg_shift;
  logic signed [7:0] cfg_offset, cfg_min, cfg_max, out_data, argmax_val;
  logic [3:0] argmax_idx;
  typedef struct packed { logic [7:0] d; logic l; } beat_t;
  typedef struct packed { logic [3:0] i; logic signed [7:0] v; } am_t;
  beat_t sb[$];
  am_t am_q[$];
  int n_chk = 0, n_fail = 0, n_in = 0, n_out = 0;
  logic signed [24:0] m_bias;
  logic [15:0] m_mult;
  logic [4:0] m_shift;
  logic m_round;
  logic signed [7:0] m_off, m_min, m_max, last_out, obs_data;
  logic obs_valid, obs_in_ready;

  always #5 clk = ~clk;

  requant_argmax_pipe dut (
    .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load), .cfg_bias(cfg_bias), .cfg_mult(cfg_mult),
    .cfg_shift(cfg_shift), .cfg_round(cfg_round), .cfg_offset(cfg_offset), .cfg_min(cfg_min),
    .cfg_max(cfg_max), .busy(busy), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .argmax_valid(argmax_valid), .argmax_idx(argmax_idx), .argmax_val(argmax_val)
  );

  always @(negedge clk)
    if (rst_n === 1'b1 && argmax_valid === 1'b1) am_q.push_back(am_t'{i: argmax_idx, v: argmax_val});

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] model(input logic signed [24:0] d);
    longint s, p, q;
    s = longint'(d) + longint'(m_bias);
    p = s * longint'(m_mult);
    if (m_round && m_shift != 0) p = p + (longint'(1) << (m_shift - 1));
    q = (p >>> m_shift) + longint'(m_off);
    if (m_min > m_max) q = longint'(m_max);
    else if (q > longint'(m_max)) q = longint'(m_max);
    else if (q < longint'(m_min)) q = longint'(m_min);
    return 8'(q);
  endfunction

  task automatic model_defaults();
    m_bias = 0; m_mult = 1; m_shift = 0; m_round = 0; m_off = 0; m_min = -128; m_max = 127;
  endtask

  task automatic step(input logic v, input logic signed [24:0] d, input logic l, input logic r);
    beat_t e;
    in_valid = v; in_data = d; in_last = l; out_ready = r;
    #1;
    obs_valid = out_valid; obs_data = out_data; obs_in_ready = in_ready;
    if (out_valid && r) begin
      last_out = out_data; n_out++; n_chk++;
      if (sb.size() == 0) begin
        n_fail++; $display("FAIL sb_unexpected got=%0d/%b required=no beat", out_data, out_last);
      end else begin
        e = sb.pop_front();
        if (out_data !== e.d || out_last !== e.l) begin
          n_fail++; $display("FAIL sb_beat got=%0d/%b required=%0d/%b", out_data, out_last, $signed(e.d), e.l);
        end
      end
    end
    if (v && in_ready) begin sb.push_back(beat_t'{d: model(d), l: l}); n_in++; end
    @(negedge clk);
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while ((sb.size() != 0 || busy) && k < 60) begin step(0, 0, 0, 1); k++; end
    n_chk++;
    if (sb.size() != 0 || busy) begin
      n_fail++; $display("FAIL %s_drain got pending=%0d busy=%b required 0/0", tag, sb.size(), busy);
    end
    repeat (2) step(0, 0, 0, 1);
  endtask

  task automatic load_cfg(input logic signed [24:0] b, input logic [15:0] m, input logic [4:0] s,
                          input logic r, input logic signed [7:0] o, input logic signed [7:0] mn,
                          input logic signed [7:0] mx);
    cfg_bias = b; cfg_mult = m; cfg_shift = s; cfg_round = r; cfg_offset = o; cfg_min = mn; cfg_max = mx;
    cfg_load = 1; in_valid = 0;
    @(negedge clk);
    cfg_load = 0;
    m_bias = b; m_mult = m; m_shift = s; m_round = r; m_off = o; m_min = mn; m_max = mx;
  endtask

  task automatic test_reset();
    rst_n = 0; cfg_load = 0; in_valid = 0; in_data = 0; in_last = 0; out_ready = 1;
    cfg_bias = 0; cfg_mult = 1; cfg_shift = 0; cfg_round = 0; cfg_offset = 0; cfg_min = -128; cfg_max = 127;
    repeat (3) @(negedge clk);
    rst_n = 1;
    #1;
    n_chk += 8;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got=%b required=0", out_valid); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b required=0", busy); end
    if (out_data !== 8'sd0) begin n_fail++; $display("FAIL rst_out_data got=%0d required=0", out_data); end
    if (out_last !== 1'b0) begin n_fail++; $display("FAIL rst_out_last got=%b required=0", out_last); end
    if (argmax_valid !== 1'b0) begin n_fail++; $display("FAIL rst_am_valid got=%b required=0", argmax_valid); end
    if (argmax_idx !== 4'd0) begin n_fail++; $display("FAIL rst_am_idx got=%0d required=0", argmax_idx); end
    if (argmax_val !== -8'sd128) begin n_fail++; $display("FAIL rst_am_val got=%0d required=-128", argmax_val); end
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got=%b required=1", in_ready); end
    @(negedge clk);
    model_defaults();
    sb.delete(); am_q.delete();
    step(1, 1000, 1, 1);
    drain("rst_default");
    n_chk++;
    if (last_out !== 8'sd127) begin n_fail++; $display("FAIL rst_default_cfg got=%0d required=127", last_out); end
    am_q.delete();
  endtask

  task automatic test_scale();
    int b[8] = '{-4, -4, -4, 0, 0, -16777216, 0, 0};
    int m[8] = '{3, 3, 3, 60000, 1, 1, 1, 1};
    int s[8] = '{2, 2, 2, 20, 0, 0, 1, 1};
    int r[8] = '{1, 0, 0, 1, 0, 0, 1, 0};
    int o[8] = '{-5, -5, -5, 0, -3, 0, 0, 0};
    int d[8] = '{101, 101, -102, 1000, -126, -16777216, -3, -3};
    int e[8] = '{68, 67, -85, 57, -128, -128, -1, -2};
    int lat;
    for (int i = 0; i < 8; i++) begin
      load_cfg(25'(b[i]), 16'(m[i]), 5'(s[i]), 1'(r[i]), 8'(o[i]), -128, 127);
      step(1, 25'(d[i]), 1, 1);
      lat = -1;
      for (int k = 1; k <= 6; k++) begin
        step(0, 0, 0, 1);
        if (obs_valid && lat < 0) lat = k;
      end
      n_chk++;
      if (last_out !== 8'(e[i])) begin n_fail++; $display("FAIL scale_%0d got=%0d required=%0d", i, last_out, e[i]); end
      if (i == 0) begin
        n_chk++;
        if (lat != 3) begin n_fail++; $display("FAIL scale_latency got=%0d required=3", lat); end
      end
      drain("scale");
    end
    am_q.delete();
  endtask

  task automatic test_clamp();
    int mn[6] = '{-128, -128, 0, 0, 10, 10};
    int mx[6] = '{127, 127, 127, 127, 5, 5};
    int d[6]  = '{1000, -1000, -1000, 50, 0, 100};
    int e[6]  = '{127, -128, 0, 50, 5, 5};
    for (int i = 0; i < 6; i++) begin
      load_cfg(0, 1, 0, 0, 0, 8'(mn[i]), 8'(mx[i]));
      step(1, 25'(d[i]), 1, 1);
      drain("clamp");
      n_chk++;
      if (last_out !== 8'(e[i])) begin n_fail++; $display("FAIL clamp_%0d got=%0d required=%0d", i, last_out, e[i]); end
    end
    am_q.delete();
  endtask

  task automatic test_argmax();
    int f1[12] = '{3, 9, 9, 1, 0, 0, 0, 0, 0, 0, 0, 50};
    int f2[3] = '{-7, -2, -9};
    am_t a;
    load_cfg(0, 1, 0, 0, 0, -128, 127);
    am_q.delete();
    for (int i = 0; i < 12; i++) step(1, 25'(f1[i]), i == 11, 1);
    drain("argmax1");
    n_chk++;
    if (am_q.size() != 1) begin n_fail++; $display("FAIL argmax1_pulses got=%0d required=1", am_q.size()); end
    if (am_q.size() > 0) begin
      a = am_q.pop_front(); n_chk++;
      if (a.i !== 4'd1 || a.v !== 8'sd9) begin n_fail++; $display("FAIL argmax1 got=%0d/%0d required=1/9", a.i, a.v); end
    end
    am_q.delete();
    for (int i = 0; i < 3; i++) step(1, 25'(f2[i]), i == 2, 1);
    drain("argmax2");
    n_chk++;
    if (am_q.size() != 1) begin n_fail++; $display("FAIL argmax2_pulses got=%0d required=1", am_q.size()); end
    if (am_q.size() > 0) begin
      a = am_q.pop_front(); n_chk++;
      if (a.i !== 4'd1 || a.v !== -8'sd2) begin n_fail++; $display("FAIL argmax2 got=%0d/%0d required=1/-2", a.i, a.v); end
    end
    n_chk++;
    if (argmax_idx !== 4'd1 || argmax_val !== -8'sd2) begin
      n_fail++; $display("FAIL argmax_hold got=%0d/%0d required=1/-2", argmax_idx, argmax_val);
    end
    am_q.delete();
  endtask

  task automatic test_back_to_back();
    int vv[12] = '{1, 1, 1, 0, 0, 1, 1, 1, 1, 1, 1, 1};
    int dd[12] = '{5, 1, 2, 0, 0, 0, 4, 4, 3, -3, 7, 7};
    int ll[12] = '{0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 1};
    int ei[4] = '{0, 1, 0, 0};
    int ev[4] = '{5, 4, -3, 7};
    int stalls = 0;
    am_t a;
    load_cfg(0, 1, 0, 0, 0, -128, 127);
    am_q.delete();
    for (int i = 0; i < 12; i++) begin
      step(1'(vv[i]), 25'(dd[i]), 1'(ll[i]), 1);
      if (vv[i] != 0 && !obs_in_ready) stalls++;
    end
    drain("b2b");
    n_chk++;
    if (stalls != 0) begin n_fail++; $display("FAIL b2b_stalls got=%0d required=0", stalls); end
    n_chk++;
    if (am_q.size() != 4) begin n_fail++; $display("FAIL b2b_pulses got=%0d required=4", am_q.size()); end
    for (int i = 0; i < 4 && am_q.size() > 0; i++) begin
      a = am_q.pop_front(); n_chk++;
      if (a.i !== 4'(ei[i]) || a.v !== 8'(ev[i])) begin
        n_fail++; $display("FAIL b2b_frame%0d got=%0d/%0d required=%0d/%0d", i, a.i, a.v, ei[i], ev[i]);
      end
    end
    am_q.delete();
  endtask

  task automatic test_backpressure();
    int in0 = n_in, out0 = n_out, nxt = 10;
    logic signed [7:0] d3;
    load_cfg(0, 1, 0, 0, 0, -128, 127);
    for (int i = 0; i < 5; i++) begin
      step(1, 25'(nxt), 0, 0);
      nxt = 10 + (n_in - in0);
      if (i == 3) d3 = obs_data;
      if (i >= 3) begin
        n_chk++;
        if (obs_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_%0d got=%b required=0", i, obs_in_ready); end
      end
      if (i == 4) begin
        n_chk++;
        if (obs_data !== d3 || d3 !== 8'sd10 || !obs_valid) begin
          n_fail++; $display("FAIL bp_hold got=%0d,%0d v=%b required=10,10 v=1", d3, obs_data, obs_valid);
        end
      end
    end
    n_chk++;
    if (n_in - in0 != 3) begin n_fail++; $display("FAIL bp_accepted got=%0d required=3", n_in - in0); end
    for (int i = 0; i < 4; i++) begin
      step(1, 25'(nxt), i == 3 && n_in - in0 == 6, 1);
      nxt = 10 + (n_in - in0);
    end
    while (n_in - in0 < 7) begin step(1, 25'(nxt), n_in - in0 == 6, 1); nxt = 10 + (n_in - in0); end
    drain("bp");
    n_chk++;
    if (n_out - out0 != 7 || n_in - in0 != 7) begin
      n_fail++; $display("FAIL bp_count got in=%0d out=%0d required 7/7", n_in - in0, n_out - out0);
    end
    am_q.delete();
  endtask

  task automatic test_reset_mid();
    int f[5] = '{100, 90, 80, 70, 60};
    int g[3] = '{1, 7, 3};
    am_t a;
    load_cfg(0, 1, 0, 0, 0, -128, 127);
    am_q.delete();
    for (int i = 0; i < 5; i++) step(1, 25'(f[i]), 0, 1);
    rst_n = 0; in_valid = 0;
    @(negedge clk);
    rst_n = 1;
    #1;
    n_chk++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_flush got out_valid=%b busy=%b required 0/0", out_valid, busy);
    end
    @(negedge clk);
    sb.delete(); model_defaults();
    repeat (4) step(0, 0, 0, 1);
    n_chk++;
    if (am_q.size() != 0) begin n_fail++; $display("FAIL rstmid_pulse got=%0d required=0", am_q.size()); end
    for (int i = 0; i < 3; i++) step(1, 25'(g[i]), i == 2, 1);
    drain("rstmid");
    n_chk++;
    if (am_q.size() != 1) begin n_fail++; $display("FAIL rstmid_pulses got=%0d required=1", am_q.size()); end
    if (am_q.size() > 0) begin
      a = am_q.pop_front(); n_chk++;
      if (a.i !== 4'd1 || a.v !== 8'sd7) begin n_fail++; $display("FAIL rstmid_argmax got=%0d/%0d required=1/7", a.i, a.v); end
    end
    am_q.delete();
  endtask

  task automatic test_cfg_busy();
    load_cfg(10, 1, 0, 0, 0, -128, 127);
    step(1, 10, 0, 1);
    n_chk++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL cfgbusy_busy got=%b required=1", busy); end
    cfg_bias = 50; cfg_load = 1;
    step(0, 0, 0, 1);
    cfg_load = 0;
    step(1, 20, 1, 1);
    drain("cfgbusy");
    n_chk++;
    if (last_out !== 8'sd30) begin n_fail++; $display("FAIL cfgbusy_ignored got=%0d required=30", last_out); end
    cfg_load = 1;
    step(1, 1, 1, 1);
    cfg_load = 0;
    drain("cfgvalid");
    n_chk++;
    if (last_out !== 8'sd11) begin n_fail++; $display("FAIL cfg_with_valid got=%0d required=11", last_out); end
    load_cfg(50, 1, 0, 0, 0, -128, 127);
    step(1, 1, 1, 1);
    drain("cfgidle");
    n_chk++;
    if (last_out !== 8'sd51) begin n_fail++; $display("FAIL cfg_idle got=%0d required=51", last_out); end
    am_q.delete();
  endtask

  task automatic test_random();
    for (int c = 0; c < 6; c++) begin
      if (c % 2 == 0)
        load_cfg(25'($urandom_range(0, 200)) - 25'sd100, 16'($urandom_range(0, 8)), 5'($urandom_range(0, 4)),
                 1'($urandom), 8'($urandom), -8'sd100, 8'($urandom_range(0, 120)));
      else
        load_cfg(25'($urandom), 16'($urandom), 5'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      for (int i = 0; i < 60; i++)
        step(1'($urandom % 4 != 0), (c % 2 == 0) ? 25'($urandom_range(0, 400)) - 25'sd200 : 25'($urandom),
             1'($urandom % 5 == 0), 1'($urandom % 4 != 0));
      drain("random");
    end
    am_q.delete();
  endtask

  initial begin
    model_defaults();
    test_reset();
    test_scale();
    test_clamp();
    test_argmax();
    test_back_to_back();
    test_backpressure();
    test_cfg_busy();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
